// File: rtl/dc_ipu_filter_pkg.sv
// dc_ipu_filter_pkg: width helpers and round/clamp shared by the IPU filter blocks
package dc_ipu_filter_pkg;

  function automatic int cw_of(input int rgb_w);
    return rgb_w / 3;
  endfunction

  function automatic int h_width(input int cw, input int w);
    return cw + w + 3;
  endfunction

  function automatic int v_width(input int cw, input int w);
    return cw + 2 * w + 5;
  endfunction

  // Round half up after removing both weight fractions, then clamp to [0, 2^cw-1].
  function automatic logic [31:0] round_clamp(input logic signed [63:0] v, input int cw, input int f);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    r = (v + (64'sd1 <<< (2 * f - 1))) >>> (2 * f);
    hi = (64'sd1 <<< cw) - 64'sd1;
    return r < 0 ? 32'd0 : (r > hi ? hi[31:0] : r[31:0]);
  endfunction

endpackage

// File: rtl/dc_ipu_filter_dot4.sv
// dc_ipu_filter_dot4: 4-tap signed multiply-accumulate, full-precision output
module dc_ipu_filter_dot4 #(
  parameter int AW = 9,
  parameter int BW = 10,
  parameter int OW = 21
) (
  input  logic signed [AW-1:0] a [0:3],
  input  logic signed [BW-1:0] b [0:3],
  output logic signed [OW-1:0] y
);

  // Operands are sign-extended to the output width so no product bit is lost.
  always_comb begin
    y = '0;
    for (int k = 0; k < 4; k++) y = y + OW'(a[k]) * OW'(b[k]);
  end

endmodule

// File: rtl/dc_ipu_filter_convolve.sv
// dc_ipu_filter_convolve: 3-stage separable 4x4 RGB convolution with valid/ready flow control
module dc_ipu_filter_convolve
  import dc_ipu_filter_pkg::*;
#(
  parameter int RGB_WIDTH          = 24,
  parameter int WEIGHT_WIDTH       = 10,
  parameter int WEIGHT_FRACT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clr,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [RGB_WIDTH-1:0]           in_texel_matrix [0:3][0:3],
  input  logic signed [WEIGHT_WIDTH-1:0] in_weights_x [0:3],
  input  logic signed [WEIGHT_WIDTH-1:0] in_weights_y [0:3],
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [RGB_WIDTH-1:0]           out_pixel
);

  localparam int CW = cw_of(RGB_WIDTH);
  localparam int W  = WEIGHT_WIDTH;
  localparam int HW = h_width(CW, W);
  localparam int VW = v_width(CW, W);

  logic                 adv, v1, v2, v3;
  logic signed [HW-1:0] h_d [0:2][0:3];
  logic signed [HW-1:0] h_q [0:2][0:3];
  logic signed [W-1:0]  wy_q [0:3];
  logic signed [VW-1:0] v_d [0:2];
  logic signed [VW-1:0] v_q [0:2];
  logic [RGB_WIDTH-1:0] pix_d, pix_q;

  // The whole pipe moves together whenever the output slot is free or being taken.
  assign adv       = out_ready | ~v3;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign out_pixel = pix_q;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    for (genvar i = 0; i < 4; i++) begin : g_row
      logic signed [CW:0] tap [0:3];
      // Texel channels are unsigned; a zero MSB keeps them positive in the signed MAC.
      always_comb for (int j = 0; j < 4; j++) tap[j] = {1'b0, in_texel_matrix[i][j][(2-c)*CW +: CW]};
      dc_ipu_filter_dot4 #(.AW(CW + 1), .BW(W), .OW(HW)) u_h (
        .a(tap),
        .b(in_weights_x),
        .y(h_d[c][i])
      );
    end
    logic signed [HW-1:0] col [0:3];
    // Gather the four row sums of this channel for the vertical pass.
    always_comb for (int i = 0; i < 4; i++) col[i] = h_q[c][i];
    dc_ipu_filter_dot4 #(.AW(HW), .BW(W), .OW(VW)) u_v (
      .a(col),
      .b(wy_q),
      .y(v_d[c])
    );
    assign pix_d[(2-c)*CW +: CW] = CW'(round_clamp(64'(v_q[c]), CW, WEIGHT_FRACT_WIDTH));
  end

  // Valid bits: clear wins over advance; bubbles travel like data.
  always_ff @(posedge clk or posedge reset)
    if (reset) {v1, v2, v3} <= 3'b000;
    else if (clr) {v1, v2, v3} <= 3'b000;
    else if (adv) {v1, v2, v3} <= {in_valid, v1, v2};

  // Datapath registers hold while stalled and carry no reset.
  always_ff @(posedge clk)
    if (adv) begin
      h_q   <= h_d;
      wy_q  <= in_weights_y;
      v_q   <= v_d;
      pix_q <= pix_d;
    end

endmodule

// File: tb/tb_dc_ipu_filter_convolve.sv
// tb_dc_ipu_filter_convolve: scoreboard bench for the 4x4 convolution stage
module tb_dc_ipu_filter_convolve;

  typedef struct {
    logic [23:0] pix;
    int          cyc;
  } ent_t;

  logic              clk, reset, clr, in_valid, in_ready, out_valid, out_ready;
  logic [23:0]       tx [0:3][0:3];
  logic signed [9:0] wxv [0:3];
  logic signed [9:0] wyv [0:3];
  logic [23:0]       out_pixel;

  ent_t        q[$];
  ent_t        e;
  int          total = 0, bad = 0, cyc = 0, nout = 0, n0;
  bit          chk_lat, stall_prev;
  logic [23:0] held;

  dc_ipu_filter_convolve dut (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_texel_matrix(tx),
    .in_weights_x(wxv),
    .in_weights_y(wyv),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pixel(out_pixel)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Direct 2-D sum over all 16 taps, then round half up and clamp.
  function automatic logic [23:0] model();
    logic [23:0] p;
    longint acc, r;
    p = '0;
    for (int c = 0; c < 3; c++) begin
      acc = 0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          acc += longint'(tx[i][j][8*(2-c) +: 8]) * longint'(wxv[j]) * longint'(wyv[i]);
      r = (acc + 32768) >>> 16;
      r = r < 0 ? 0 : (r > 255 ? 255 : r);
      p[8*(2-c) +: 8] = r[7:0];
    end
    return p;
  endfunction

  task automatic zero_tex();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) tx[i][j] = '0;
  endtask

  task automatic wts(input int x0, x1, x2, x3, y0, y1, y2, y3);
    wxv[0] = 10'(x0); wxv[1] = 10'(x1); wxv[2] = 10'(x2); wxv[3] = 10'(x3);
    wyv[0] = 10'(y0); wyv[1] = 10'(y1); wyv[2] = 10'(y2); wyv[3] = 10'(y3);
  endtask

  task automatic rnd();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) tx[i][j] = 24'($urandom);
    for (int k = 0; k < 4; k++) begin
      wxv[k] = 10'(int'($urandom_range(0, 360)) - 60);
      wyv[k] = 10'(int'($urandom_range(0, 360)) - 60);
    end
  endtask

  // Present the current inputs until accepted; expected result enters the scoreboard on acceptance.
  task automatic send(input bit use_exp = 0, input logic [23:0] exp = '0);
    int n = 0;
    in_valid = 1;
    forever begin
      @(negedge clk);
      if (in_ready && !clr) begin
        q.push_back('{pix: use_exp ? exp : model(), cyc: cyc});
        break;
      end
      if (++n > 200) begin
        chk("accept_timeout", in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output side: compare in order, check stall behaviour, flush on clear/reset.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      stall_prev = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("stale_out", out_valid, 0);
        else begin
          e = q.pop_front();
          chk("pixel", out_pixel, e.pix);
          if (chk_lat) chk("latency", cyc - e.cyc, 3);
          nout++;
        end
      end
      if (out_valid && !out_ready) begin
        chk("bp_in_ready", in_ready, 0);
        if (stall_prev) chk("bp_hold", out_pixel, held);
        held = out_pixel;
        stall_prev = 1;
      end else stall_prev = 0;
      if (clr) q.delete();
    end
  end

  initial begin
    reset = 1; clr = 0; in_valid = 0; out_ready = 1; chk_lat = 1;
    zero_tex();
    wts(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 0;
    @(posedge clk);
    #1;
    rnd();
    wts(0, 256, 0, 0, 0, 256, 0, 0);
    tx[1][1] = 24'h123456;
    send(1, 24'h123456);
    drain();
    zero_tex();
    wts(0, 128, 128, 0, 0, 128, 128, 0);
    tx[1][1] = 24'd10 << 16; tx[1][2] = 24'd20 << 16; tx[2][1] = 24'd30 << 16; tx[2][2] = 24'd41 << 16;
    send(1, 24'h190000);
    zero_tex();
    wts(0, 128, 128, 0, 0, 256, 0, 0);
    tx[1][1] = 24'd10 << 16; tx[1][2] = 24'd11 << 16;
    send(1, 24'h0B0000);
    zero_tex();
    wts(-32, 288, 0, 0, 0, 256, 0, 0);
    tx[1][0] = 24'hFF0000;
    send(1, 24'h000000);
    zero_tex();
    wts(0, 288, 0, -32, 0, 256, 0, 0);
    tx[1][1] = 24'hFF6400;
    send(1, 24'hFF7100);
    drain();
    for (int k = 0; k < 10; k++) begin
      rnd();
      send();
    end
    drain();
    chk_lat = 0;
    n0 = nout;
    fork
      for (int k = 0; k < 8; k++) begin
        rnd();
        send();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    drain();
    chk("bp_count", nout - n0, 8);
    chk_lat = 1;
    for (int k = 0; k < 3; k++) begin
      rnd();
      send();
    end
    rnd();
    in_valid = 1;
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
    in_valid = 0;
    chk("clr_out_valid", out_valid, 0);
    rnd();
    send();
    drain();
    for (int k = 0; k < 3; k++) begin
      rnd();
      send();
    end
    @(posedge clk);
    #3;
    chk("pre_rst_valid", out_valid, 1);
    reset = 1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    reset = 0;
    chk("post_rst_in_ready", in_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", out_valid, 0);
    rnd();
    send();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
